// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one request at a time, unaligned accesses split across
// two word cycles on a word-addressed data memory with byte enables.
module riscv_lsu #(
  parameter int XLEN          = 32,
  parameter int DMEM_ADDR_BIT = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [2:0]               i_req_funct3,
  input  logic [DMEM_ADDR_BIT-1:0] i_req_addr,
  input  logic [XLEN-1:0]          i_req_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [XLEN-1:0]          o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic                     o_dmem_wr_en,
  output logic [XLEN-1:0]          o_dmem_data,
  output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
  output logic [XLEN/8-1:0]        o_dmem_byte_sel,
  input  logic [XLEN-1:0]          i_dmem_data
);

  localparam int WA = DMEM_ADDR_BIT - 2;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [DMEM_ADDR_BIT-1:0] addr_q, addr_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic [XLEN-1:0]          lo_q, lo_d;
  logic [XLEN-1:0]          rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [WA-1:0]            dmem_addr_q, dmem_addr_d;

  logic [1:0]    off;
  logic [2:0]    size;
  logic [7:0]    mask8;
  logic [63:0]   data64;
  logic          split;
  logic [WA-1:0] word0, word1;
  logic          req_illegal;

  function automatic logic illegal(input logic we, input logic [2:0] f3);
    if (we) illegal = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    else    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Realign the (possibly two-word) load window and apply width/extension.
  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] sh;
    sh = 32'({hi, lo} >> {o, 3'b000});
    case (f3)
      3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extend = sh;
      3'b100:  extend = {24'b0, sh[7:0]};
      3'b101:  extend = {16'b0, sh[15:0]};
      default: extend = '0;
    endcase
  endfunction

  always_comb begin
    off = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    case (size)
      3'd1:    mask8 = 8'h01 << off;
      3'd2:    mask8 = 8'h03 << off;
      default: mask8 = 8'h0F << off;
    endcase
    data64      = {32'b0, wdata_q} << {off, 3'b000};
    split       = ({2'b0, off} + {1'b0, size}) > 4'd4;
    word0       = addr_q[DMEM_ADDR_BIT-1:2];
    word1       = word0 + WA'(1);
    req_illegal = illegal(i_req_we, i_req_funct3);
  end

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    funct3_d        = funct3_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    lo_d            = lo_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    dmem_addr_d     = dmem_addr_q;
    o_req_ready     = 1'b0;
    o_dmem_wr_en    = 1'b0;
    o_dmem_byte_sel = '0;
    o_dmem_data     = '0;
    o_dmem_addr     = dmem_addr_q;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          we_d     = i_req_we;
          funct3_d = i_req_funct3;
          addr_d   = i_req_addr;
          wdata_d  = i_req_wdata;
          err_d    = req_illegal;
          rdata_d  = '0;
          state_d  = req_illegal ? RESP : ACC0;
        end
      end
      ACC0: begin
        o_dmem_addr  = word0;
        dmem_addr_d  = word0;
        o_dmem_wr_en = we_q;
        if (we_q) begin
          o_dmem_byte_sel = mask8[3:0];
          o_dmem_data     = data64[31:0];
        end
        lo_d = i_dmem_data;
        if (split) state_d = ACC1;
        else begin
          rdata_d = we_q ? '0 : extend(funct3_q, off, 32'b0, i_dmem_data);
          state_d = RESP;
        end
      end
      ACC1: begin
        o_dmem_addr  = word1;
        dmem_addr_d  = word1;
        o_dmem_wr_en = we_q;
        if (we_q) begin
          o_dmem_byte_sel = mask8[7:4];
          o_dmem_data     = data64[63:32];
        end
        rdata_d = we_q ? '0 : extend(funct3_q, off, i_dmem_data, lo_q);
        state_d = RESP;
      end
      RESP: if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      dmem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      dmem_addr_q <= dmem_addr_d;
    end
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a byte-enabled word memory model.
module tb_riscv_lsu;
  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_req_valid = 1'b0, i_req_we = 1'b0, i_rsp_ready = 1'b0;
  logic [2:0]  i_req_funct3 = '0;
  logic [11:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_dmem_wr_en;
  logic [31:0] o_rsp_rdata, o_dmem_data, i_dmem_data;
  logic [9:0]  o_dmem_addr;
  logic [3:0]  o_dmem_byte_sel;

  logic [31:0] mem [0:1023];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;

  int errors = 0, checks = 0, lat, nwr;
  logic [9:0]  r_addr [4];
  logic [3:0]  r_sel  [4];
  logic [31:0] r_data [4];

  riscv_lsu #(.XLEN(32), .DMEM_ADDR_BIT(12)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_dmem_wr_en(o_dmem_wr_en), .o_dmem_data(o_dmem_data),
    .o_dmem_addr(o_dmem_addr), .o_dmem_byte_sel(o_dmem_byte_sel), .i_dmem_data(i_dmem_data)
  );

  always #5 i_clk = ~i_clk;

  assign i_dmem_data = mem[o_dmem_addr];

  always @(posedge i_clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (o_dmem_wr_en)
      for (int b = 0; b < 4; b++)
        if (o_dmem_byte_sel[b]) mem[o_dmem_addr][8*b +: 8] <= o_dmem_data[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge i_clk); tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge i_clk); tb_we = 1'b0;
  endtask

  // Issue one request; lat counts edges from the handshake edge (inclusive) to rsp_valid.
  task automatic run(input logic we, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = wd;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    lat = 0; nwr = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge i_clk);
      if (o_rsp_valid) begin lat = k; break; end
      if (k <= 4) begin
        r_addr[k-1] = o_dmem_addr; r_sel[k-1] = o_dmem_byte_sel; r_data[k-1] = o_dmem_data;
      end
      if (o_dmem_wr_en) nwr++;
    end
  endtask

  task automatic ack();
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [11:0] a,
                    input logic [31:0] exp, input int exp_lat);
    run(1'b0, f3, a, 32'h0);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, o_rsp_rdata, exp);
    chk({tag, "_err"}, o_rsp_err, 1'b0);
    chk({tag, "_nwr"}, nwr, 0);
    ack();
  endtask

  initial begin
    // Reset with a request held valid: it must be ignored.
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b010; i_req_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0; i_req_valid = 1'b0;
    chk("rst_valid", o_rsp_valid, 1'b0);
    chk("rst_err", o_rsp_err, 1'b0);
    chk("rst_rdata", o_rsp_rdata, 32'h0);
    chk("rst_wr_en", o_dmem_wr_en, 1'b0);
    chk("rst_sel", o_dmem_byte_sel, 4'h0);
    chk("rst_addr", o_dmem_addr, 10'h0);
    chk("rst_data", o_dmem_data, 32'h0);
    chk("rst_ready", o_req_ready, 1'b1);
    @(negedge i_clk);
    chk("rst_ign_wr", o_dmem_wr_en, 1'b0);
    chk("rst_ign_ready", o_req_ready, 1'b1);

    preload(10'h004, 32'h0); preload(10'h005, 32'h0);

    // Aligned SW
    run(1'b1, 3'b010, 12'h010, 32'h11223344);
    chk("sw_lat", lat, 2);
    chk("sw_nwr", nwr, 1);
    chk("sw_addr", r_addr[0], 10'h004);
    chk("sw_sel", r_sel[0], 4'hF);
    chk("sw_data", r_data[0], 32'h11223344);
    chk("sw_err", o_rsp_err, 1'b0);
    chk("sw_rdata", o_rsp_rdata, 32'h0);
    chk("sw_hold_addr", o_dmem_addr, 10'h004);
    chk("sw_resp_sel", o_dmem_byte_sel, 4'h0);
    chk("sw_resp_data", o_dmem_data, 32'h0);
    chk("sw_resp_ready", o_req_ready, 1'b0);
    chk("sw_mem", mem[4], 32'h11223344);
    ack();

    // Loads from 0x80FF7F01
    preload(10'h004, 32'h80FF7F01);
    ld("lb_011", 3'b000, 12'h011, 32'h0000007F, 2);
    ld("lb_013", 3'b000, 12'h013, 32'hFFFFFF80, 2);
    ld("lhu_012", 3'b101, 12'h012, 32'h000080FF, 2);
    ld("lh_012", 3'b001, 12'h012, 32'hFFFF80FF, 2);
    ld("lbu_013", 3'b100, 12'h013, 32'h00000080, 2);
    ld("lw_010", 3'b010, 12'h010, 32'h80FF7F01, 2);

    // Split LW wrapping at the top word
    preload(10'h3FF, 32'hDEADBEEF); preload(10'h000, 32'h12345678);
    ld("lw_top", 3'b010, 12'hFFE, 32'h5678DEAD, 3);
    chk("lw_top_a0", r_addr[0], 10'h3FF);
    chk("lw_top_a1", r_addr[1], 10'h000);

    // Split SW across words 4/5
    run(1'b1, 3'b010, 12'h013, 32'hAABBCCDD);
    chk("ssw_lat", lat, 3);
    chk("ssw_nwr", nwr, 2);
    chk("ssw_a0", r_addr[0], 10'h004);
    chk("ssw_s0", r_sel[0], 4'h8);
    chk("ssw_d0", r_data[0], 32'hDD000000);
    chk("ssw_a1", r_addr[1], 10'h005);
    chk("ssw_s1", r_sel[1], 4'h7);
    chk("ssw_d1", r_data[1], 32'h00AABBCC);
    ack();
    chk("ssw_mem4", mem[4], 32'hDDFF7F01);
    chk("ssw_mem5", mem[5], 32'h00AABBCC);

    // Illegal load, response held off for 3 cycles
    run(1'b0, 3'b011, 12'h010, 32'h0);
    chk("ill_lat", lat, 1);
    chk("ill_err", o_rsp_err, 1'b1);
    chk("ill_rdata", o_rsp_rdata, 32'h0);
    chk("ill_wr_en", o_dmem_wr_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("ill_hold_valid", o_rsp_valid, 1'b1);
      chk("ill_hold_err", o_rsp_err, 1'b1);
      chk("ill_hold_rdata", o_rsp_rdata, 32'h0);
    end
    ack();
    chk("ill_done", o_rsp_valid, 1'b0);

    // Illegal store makes no write
    run(1'b1, 3'b100, 12'h010, 32'hCAFEF00D);
    chk("ills_lat", lat, 1);
    chk("ills_err", o_rsp_err, 1'b1);
    ack();
    chk("ills_mem", mem[4], 32'hDDFF7F01);

    // Reset during ACC0 of a split SW
    preload(10'h008, 32'h0); preload(10'h009, 32'h0);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b010;
    i_req_addr = 12'h022; i_req_wdata = 32'h55667788;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("rmid_wr_en", o_dmem_wr_en, 1'b1);
    chk("rmid_sel", o_dmem_byte_sel, 4'hC);
    chk("rmid_data", o_dmem_data, 32'h77880000);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rmid_ready", o_req_ready, 1'b1);
    chk("rmid_valid", o_rsp_valid, 1'b0);
    chk("rmid_wr_off", o_dmem_wr_en, 1'b0);
    chk("rmid_addr", o_dmem_addr, 10'h0);
    @(negedge i_clk);
    chk("rmid_valid2", o_rsp_valid, 1'b0);
    chk("rmid_wr_off2", o_dmem_wr_en, 1'b0);
    chk("rmid_mem8", mem[8], 32'h77880000);
    chk("rmid_mem9", mem[9], 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
